// File: rtl/sdadc_postproc.sv
// sdadc_postproc
// Post-processing stage behind the sinc3 decimator. It takes the
// offset-binary filtered word and turns it into a calibrated two's-complement
// sample through offset removal, Q2.14 gain scaling and saturation. Two
// consumers are fed from the calibrated stream:
// - a block averager for the control loop;
// - a debounced, sticky over-level trip for buck converter protection.
//
// Build option:
//   SDADC_POSTPROC_AVG_EN  defined   -> block averager is built
//                          undefined -> avg_out/avg_en are tied to 0
//
// Parameters:
//   AVG_LOG2  averager window = 2^AVG_LOG2 samples (1..8)
//   TRIP_CNT  consecutive over-level samples that set trip (1..255)
//
// Ports:
//   mclk1        in   block clock, rising edge
//   reset        in   synchronous active-high reset
//   data_in      in   16b offset-binary filtered word (0x8000 = zero)
//   data_in_en   in   one-cycle strobe qualifying data_in
//   offset       in   16b signed offset, subtracted after conversion
//   gain         in   16b unsigned Q2.14 gain (0x4000 = 1.0)
//   trip_level   in   15b unsigned magnitude threshold
//   trip_clr     in   one-cycle clear of the sticky trip
//   data_out     out  16b signed calibrated sample (held between strobes)
//   data_out_en  out  strobe, 3 cycles after data_in_en
//   avg_out      out  16b signed window average
//   avg_en       out  strobe, 1 cycle after the window's last data_out_en
//   trip         out  sticky over-level flag
module sdadc_postproc #(
    parameter int AVG_LOG2 = 4,
    parameter int TRIP_CNT = 3
) (
    input  logic               mclk1,
    input  logic               reset,
    input  logic [15:0]        data_in,
    input  logic               data_in_en,
    input  logic [15:0]        offset,
    input  logic [15:0]        gain,
    input  logic [14:0]        trip_level,
    input  logic               trip_clr,
    output logic signed [15:0] data_out,
    output logic               data_out_en,
    output logic signed [15:0] avg_out,
    output logic               avg_en,
    output logic               trip
);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 8 || TRIP_CNT < 1 || TRIP_CNT > 255) begin : g_param_check
        $error("sdadc_postproc: AVG_LOG2 must be 1..8 and TRIP_CNT 1..255");
    end

    localparam logic [7:0] TRIP_MAX = 8'(TRIP_CNT);

    // Drop the 14 fractional gain bits (floor) and clamp to the 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] p);
        logic signed [33:0] q;
        q = p >>> 14;
        if (q > 34'sd32767)
            return 16'sh7FFF;
        else if (q < -34'sd32768)
            return 16'sh8000;
        else
            return q[15:0];
    endfunction

    // Magnitude needs 17 bits so that -32768 maps to 32768.
    function automatic logic [16:0] mag17(input logic signed [15:0] v);
        logic signed [16:0] e;
        e = {v[15], v};
        return (e < 0) ? 17'(-e) : 17'(e);
    endfunction

    logic signed [17:0] w_d_p0;
    logic signed [17:0] r_d_p1;
    logic               r_vld_p1;
    logic signed [33:0] w_prod_p1;
    logic signed [33:0] r_prod_p2;
    logic               r_vld_p2;

    // Stage 0 -> 1: offset binary to two's complement (invert MSB), remove offset.
    // 18 bits hold the full difference range of two 16-bit signed values.
    assign w_d_p0 = $signed({{2{~data_in[15]}}, ~data_in[15], data_in[14:0]})
                  - $signed({{2{offset[15]}}, offset});

    // Stage 1 -> 2: gain is unsigned, so it enters the signed multiply zero-extended.
    assign w_prod_p1 = $signed({{16{r_d_p1[17]}}, r_d_p1}) * $signed({18'd0, gain});

    always_ff @(posedge mclk1) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            data_out_en <= 1'b0;
        end else begin
            r_vld_p1    <= data_in_en;
            r_vld_p2    <= r_vld_p1;
            data_out_en <= r_vld_p2;
        end
    end

    always_ff @(posedge mclk1) begin
        if (data_in_en)
            r_d_p1 <= w_d_p0;
        if (r_vld_p1)
            r_prod_p2 <= w_prod_p1;
    end

    // Stage 2 -> 3: rescale and saturate; the output register doubles as the hold.
    always_ff @(posedge mclk1) begin
        if (reset)
            data_out <= '0;
        else if (r_vld_p2)
            data_out <= sat16(r_prod_p2);
    end

`ifdef SDADC_POSTPROC_AVG_EN
    localparam int ACC_W = 16 + AVG_LOG2;

    logic signed [ACC_W-1:0] r_acc;
    logic [AVG_LOG2-1:0]     r_cnt;
    logic signed [ACC_W-1:0] w_sum;

    assign w_sum = r_acc + $signed({{AVG_LOG2{data_out[15]}}, data_out});

    // The window's last sample is folded in directly, so the accumulator can
    // restart at zero on the same edge and windows never overlap.
    always_ff @(posedge mclk1) begin
        if (reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            avg_out <= '0;
            avg_en  <= 1'b0;
        end else begin
            avg_en <= 1'b0;
            if (data_out_en) begin
                if (r_cnt == '1) begin
                    avg_out <= 16'(w_sum >>> AVG_LOG2);
                    avg_en  <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign avg_out = '0;
    assign avg_en  = 1'b0;
`endif

    logic [7:0] r_tcnt;
    logic       w_over;

    assign w_over = mag17(data_out) > {2'b00, trip_level};

    // trip follows the registered count, so it rises one cycle after the count
    // saturates. A clear beats a coincident sample, which is then not counted.
    always_ff @(posedge mclk1) begin
        if (reset || trip_clr) begin
            r_tcnt <= '0;
            trip   <= 1'b0;
        end else begin
            if (r_tcnt == TRIP_MAX)
                trip <= 1'b1;
            if (data_out_en) begin
                if (!w_over)
                    r_tcnt <= '0;
                else if (r_tcnt != TRIP_MAX)
                    r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

endmodule
